// File: rtl/pc_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared state encoding and PC constants for the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int          c_STATE_W  = 3;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_PC_INC   = 32'd1;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer_if
// Brief    : Instruction-memory, decode and branch-resolution signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        br_valid;
    logic        branch;
    logic        alu_zero;
    logic [31:0] sign_out;
    logic [31:0] br_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready,
        input  br_valid, branch, alu_zero, sign_out, br_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready,
        output br_valid, branch, alu_zero, sign_out, br_pc
    );

endinterface : pc_fetch_sequencer_if
`default_nettype wire

// File: rtl/pc_fetch_sequencer_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_calc
// Brief    : Branch target, sequential next-PC and taken-redirect decode.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_calc #(
    parameter logic [31:0] PC_INC = 32'd1
) (
    input  wire logic [31:0] i_pc,
    input  wire logic [31:0] i_br_pc,
    input  wire logic [31:0] i_sign_out,
    input  wire logic        i_br_valid,
    input  wire logic        i_branch,
    input  wire logic        i_alu_zero,
    input  wire logic        i_active,
    output logic [31:0]      o_target,
    output logic [31:0]      o_pc_next,
    output logic             o_taken
);

    // Offsets are relative to the instruction after the branch; sums wrap mod 2^32.
    assign o_target  = i_br_pc + 32'd1 + i_sign_out;
    assign o_pc_next = i_pc + PC_INC;
    assign o_taken   = i_active & i_br_valid & i_branch & i_alu_zero;

endmodule : pc_target_calc
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : Word-addressed PC sequencing, instruction fetch and decode hand-off.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] PC_INC   = c_PC_INC
) (
    input  wire logic               clock,
    input  wire logic               reset_n,
    input  wire logic               start,
    input  wire logic               halt,
    pc_fetch_sequencer_if.master    bus,
    output logic                    flush,
    output logic [31:0]             fetch_count
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic [31:0] r_instr_out;
    logic [31:0] r_instr_pc;
    logic        r_flush;
    logic [31:0] r_fetch_count;
    logic        r_discard;

    logic        w_active;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_pc_next;

    assign w_active = (r_state != ST_IDLE) && (r_state != ST_HALTED);

    pc_target_calc #(
        .PC_INC (PC_INC)
    ) u_target_calc (
        .i_pc       (r_pc),
        .i_br_pc    (bus.br_pc),
        .i_sign_out (bus.sign_out),
        .i_br_valid (bus.br_valid),
        .i_branch   (bus.branch),
        .i_alu_zero (bus.alu_zero),
        .i_active   (w_active),
        .o_target   (w_target),
        .o_pc_next  (w_pc_next),
        .o_taken    (w_taken)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr_out   <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_flush       <= 1'b0;
            r_fetch_count <= 32'd0;
            r_discard     <= 1'b0;
        end else begin
            r_flush <= w_taken;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                    end
                end

                ST_REQ: begin
                    // A redirect alongside acceptance still lets the old-address
                    // request finish; its response is marked for discard.
                    if (bus.imem_ready) begin
                        r_state    <= ST_WAIT;
                        r_imem_req <= 1'b0;
                        r_discard  <= w_taken;
                    end
                    if (w_taken) begin
                        r_pc <= w_target;
                    end
                end

                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_discard <= 1'b0;
                        if (r_discard || w_taken) begin
                            r_state    <= ST_REQ;
                            r_imem_req <= 1'b1;
                            if (w_taken) begin
                                r_pc <= w_target;
                            end
                        end else begin
                            r_instr_out   <= bus.imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= w_pc_next;
                            r_state       <= ST_HOLD;
                        end
                    end else if (w_taken) begin
                        r_discard <= 1'b1;
                        r_pc      <= w_target;
                    end
                end

                ST_HOLD: begin
                    if (w_taken) begin
                        // Handshake in the redirect cycle is counted; decode drops it on flush.
                        if (bus.instr_ready) begin
                            r_fetch_count <= r_fetch_count + 32'd1;
                        end
                        r_instr_valid <= 1'b0;
                        r_pc          <= w_target;
                        r_state       <= ST_REQ;
                        r_imem_req    <= 1'b1;
                    end else if (bus.instr_ready) begin
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_instr_valid <= 1'b0;
                        if (halt) begin
                            r_state <= ST_HALTED;
                        end else begin
                            r_state    <= ST_REQ;
                            r_imem_req <= 1'b1;
                        end
                    end
                end

                ST_HALTED: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_discard     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr_out   = r_instr_out;
    assign bus.instr_pc    = r_instr_pc;
    assign flush           = r_flush;
    assign fetch_count     = r_fetch_count;

endmodule : pc_fetch_sequencer
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_sequencer
// Brief    : Directed self-checking bench for pc_fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        halt;
    logic        flush;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .halt        (halt),
        .bus         (bus),
        .flush       (flush),
        .fetch_count (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the falling edge of a REQ cycle with imem_ready=1 and instr_ready=1.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data, input logic [31:0] cnt);
        chk("req_hi", {31'd0, bus.imem_req}, 32'd1);
        chk("req_addr", bus.imem_addr, pc);
        @(negedge clock);
        chk("wait_req_lo", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        @(negedge clock);
        bus.imem_rvalid = 1'b0;
        chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("hold_pc", bus.instr_pc, pc);
        chk("hold_data", bus.instr_out, data);
        chk("hold_addr_inc", bus.imem_addr, pc + 32'd1);
        @(negedge clock);
        chk("count", fetch_count, cnt);
        chk("valid_drop", {31'd0, bus.instr_valid}, 32'd0);
        chk("flush_lo", {31'd0, flush}, 32'd0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset_n         = 1'b0;
        start           = 1'b0;
        halt            = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.instr_ready = 1'b0;
        bus.br_valid    = 1'b0;
        bus.branch      = 1'b0;
        bus.alu_zero    = 1'b0;
        bus.sign_out    = 32'd0;
        bus.br_pc       = 32'd0;

        // Reset state
        @(negedge clock);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr_out, 32'd0);
        chk("rst_ipc", bus.instr_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        reset_n         = 1'b1;
        start           = 1'b1;
        bus.imem_ready  = 1'b1;
        bus.instr_ready = 1'b1;
        @(negedge clock);

        // Sequential fetch of PCs 0,1,2
        fetch_one(32'd0, 32'hA000_0000, 32'd1);
        fetch_one(32'd1, 32'hA000_0001, 32'd2);
        fetch_one(32'd2, 32'hA000_0002, 32'd3);

        // Taken branch during WAIT: 5 + 1 - 3 = 3, in-flight response dropped
        chk("p2_addr", bus.imem_addr, 32'd3);
        @(negedge clock);
        bus.br_valid = 1'b1;
        bus.branch   = 1'b1;
        bus.alu_zero = 1'b1;
        bus.br_pc    = 32'd5;
        bus.sign_out = 32'hFFFF_FFFD;
        @(negedge clock);
        chk("p2_flush_hi", {31'd0, flush}, 32'd1);
        chk("p2_req_lo", {31'd0, bus.imem_req}, 32'd0);
        bus.br_valid    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clock);
        bus.imem_rvalid = 1'b0;
        chk("p2_flush_lo", {31'd0, flush}, 32'd0);
        chk("p2_dropped", {31'd0, bus.instr_valid}, 32'd0);
        chk("p2_refetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("p2_refetch_addr", bus.imem_addr, 32'd3);
        chk("p2_count", fetch_count, 32'd3);
        fetch_one(32'd3, 32'hA000_0003, 32'd4);

        // Same branch not taken: sequence continues
        chk("p3_addr", bus.imem_addr, 32'd4);
        @(negedge clock);
        bus.br_valid = 1'b1;
        bus.alu_zero = 1'b0;
        @(negedge clock);
        chk("p3_flush_lo", {31'd0, flush}, 32'd0);
        bus.br_valid    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hA000_0004;
        @(negedge clock);
        bus.imem_rvalid = 1'b0;
        chk("p3_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("p3_ipc", bus.instr_pc, 32'd4);
        chk("p3_addr_inc", bus.imem_addr, 32'd5);
        @(negedge clock);
        chk("p3_count", fetch_count, 32'd5);
        chk("p3_flush_lo2", {31'd0, flush}, 32'd0);

        // Redirect in HOLD without instr_ready: 5 + 1 + 1 = 7
        bus.instr_ready = 1'b0;
        @(negedge clock);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hA000_0005;
        @(negedge clock);
        bus.imem_rvalid = 1'b0;
        chk("p4_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("p4_ipc", bus.instr_pc, 32'd5);
        bus.br_valid = 1'b1;
        bus.alu_zero = 1'b1;
        bus.br_pc    = 32'd5;
        bus.sign_out = 32'd1;
        @(negedge clock);
        chk("p4_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
        chk("p4_count", fetch_count, 32'd5);
        chk("p4_flush_hi", {31'd0, flush}, 32'd1);
        chk("p4_req", {31'd0, bus.imem_req}, 32'd1);
        chk("p4_target", bus.imem_addr, 32'd7);
        bus.br_valid    = 1'b0;
        bus.instr_ready = 1'b1;

        // Halt at handshake of PC 7
        @(negedge clock);
        chk("p5_flush_lo", {31'd0, flush}, 32'd0);
        chk("p5_req_lo", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hA000_0007;
        halt            = 1'b1;
        @(negedge clock);
        bus.imem_rvalid = 1'b0;
        chk("p5_ipc", bus.instr_pc, 32'd7);
        chk("p5_data", bus.instr_out, 32'hA000_0007);
        chk("p5_addr", bus.imem_addr, 32'd8);
        @(negedge clock);
        chk("p5_halt_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("p5_halt_req", {31'd0, bus.imem_req}, 32'd0);
        chk("p5_halt_count", fetch_count, 32'd6);
        bus.br_valid = 1'b1;
        bus.br_pc    = 32'd20;
        bus.sign_out = 32'd0;
        @(negedge clock);
        chk("p5_br_ign_flush", {31'd0, flush}, 32'd0);
        chk("p5_br_ign_addr", bus.imem_addr, 32'd8);
        chk("p5_br_ign_req", {31'd0, bus.imem_req}, 32'd0);
        bus.br_valid = 1'b0;
        @(negedge clock);
        chk("p5_frozen_addr", bus.imem_addr, 32'd8);
        chk("p5_frozen_req", {31'd0, bus.imem_req}, 32'd0);

        // Reset, one fetch, then asynchronous reset mid-WAIT
        halt    = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        fetch_one(32'd0, 32'hB000_0000, 32'd1);
        @(negedge clock);
        chk("p6_wait_addr", bus.imem_addr, 32'd1);
        chk("p6_wait_req", {31'd0, bus.imem_req}, 32'd0);
        start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("p6_async_addr", bus.imem_addr, 32'd0);
        chk("p6_async_count", fetch_count, 32'd0);
        chk("p6_async_instr", bus.instr_out, 32'd0);
        chk("p6_async_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("p6_async_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clock);
        reset_n         = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h5555_AAAA;
        @(negedge clock);
        bus.imem_rvalid = 1'b0;
        chk("p6_stale_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("p6_stale_instr", bus.instr_out, 32'd0);
        chk("p6_idle_req", {31'd0, bus.imem_req}, 32'd0);
        chk("p6_idle_addr", bus.imem_addr, 32'd0);
        start = 1'b1;
        @(negedge clock);
        chk("p6_restart_req", {31'd0, bus.imem_req}, 32'd1);
        chk("p6_restart_addr", bus.imem_addr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_fetch_sequencer
`default_nettype wire
